// File: rtl/ascii_pkg.sv
// ascii_pkg
//   Shared constants, FSM state type and character-class helper for the
//   digit-serial ASCII decimal adder.
package ascii_pkg;

    localparam logic [6:0] ASCII_ZERO = 7'h30;
    localparam logic [6:0] ASCII_NINE = 7'h39;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when the character is one of '0'..'9'.
    function automatic logic is_ascii_digit(input logic [6:0] i_chr);
        return (i_chr >= ASCII_ZERO) && (i_chr <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add
//   Combinational single-digit BCD adder with carry in/out.
//   Ports:
//     i_a, i_b    4-bit digits (nibbles above 9 are accepted as-is)
//     i_carry     carry from the previous digit
//     o_digit     result digit, sum minus ten when the sum exceeds nine
//     o_carry     carry into the next digit
module bcd_digit_add (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_carry,
    output logic [3:0] o_digit,
    output logic       o_carry
);

    logic [4:0] w_sum;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_carry};
    assign o_carry = (w_sum > 5'd9);
    // Subtracting ten modulo 16 gives the same low nibble as a 5-bit
    // subtraction, including the out-of-range sums from non-digit input.
    assign o_digit = o_carry ? (w_sum[3:0] - 4'd10) : w_sum[3:0];

endmodule

// File: rtl/ascii_seq_adder.sv
// ascii_seq_adder
//   Digit-serial adder for two NDIG-digit ASCII decimal operands. One digit
//   is added per clock, units first, through a single shared BCD digit adder.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     in_valid/in_ready   operand handshake (in_ready only in IDLE)
//     a_ascii, b_ascii    operands, 7 bits per digit, digit 0 = units
//     out_valid/out_ready result handshake
//     y_ascii             NDIG+1 digit ASCII sum, top digit is the carry
//     err                 a non-digit character was seen in the operands
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   ADD   | adding digit r_idx each cycle
//   DONE  | result held until out_ready
module ascii_seq_adder
    import ascii_pkg::*;
#(
    parameter int NDIG = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7*NDIG-1:0]       a_ascii,
    input  logic [7*NDIG-1:0]       b_ascii,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7*(NDIG+1)-1:0]   y_ascii,
    output logic                    err
);

    localparam int              IDXW     = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7*NDIG-1:0]       r_a;
    logic [7*NDIG-1:0]       r_b;
    logic [7*(NDIG+1)-1:0]   r_y;
    logic [IDXW-1:0]         r_idx;
    logic                    r_carry;
    logic                    r_err;

    logic [6:0]              w_a_chr;
    logic [6:0]              w_b_chr;
    logic [3:0]              w_digit;
    logic                    w_carry_nxt;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_bad_chr;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign y_ascii   = r_y;
    assign err       = r_err;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_last    = (r_idx == LAST_IDX);

    // Select the operand characters for the digit currently being added.
    always_comb begin
        w_a_chr = '0;
        w_b_chr = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_chr = r_a[7*i +: 7];
                w_b_chr = r_b[7*i +: 7];
            end
        end
    end

    assign w_bad_chr = !is_ascii_digit(w_a_chr) || !is_ascii_digit(w_b_chr);

    bcd_digit_add u_digit_add (
        .i_a     (w_a_chr[3:0]),
        .i_b     (w_b_chr[3:0]),
        .i_carry (r_carry),
        .o_digit (w_digit),
        .o_carry (w_carry_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ADD;
                end
            end
            ADD: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_y     <= {(NDIG+1){ASCII_ZERO}};
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a_ascii;
                        r_b     <= b_ascii;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                ADD: begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (r_idx == IDXW'(i)) begin
                            r_y[7*i +: 7] <= ASCII_ZERO | {3'b000, w_digit};
                        end
                    end
                    r_carry <= w_carry_nxt;
                    if (w_bad_chr) begin
                        r_err <= 1'b1;
                    end
                    if (w_last) begin
                        r_y[7*NDIG +: 7] <= ASCII_ZERO | {6'b000000, w_carry_nxt};
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_seq_adder.sv
module tb_ascii_seq_adder;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [13:0] a_ascii;
    logic [13:0] b_ascii;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] y_ascii;
    logic        err;

    logic        in_valid2;
    logic        in_ready2;
    logic [27:0] a_ascii2;
    logic [27:0] b_ascii2;
    logic        out_valid2;
    logic        out_ready2;
    logic [34:0] y_ascii2;
    logic        err2;

    int n_assert;
    int n_fail;

    ascii_seq_adder #(.NDIG(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_ascii   (a_ascii),
        .b_ascii   (b_ascii),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_ascii   (y_ascii),
        .err       (err)
    );

    ascii_seq_adder #(.NDIG(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a_ascii   (a_ascii2),
        .b_ascii   (b_ascii2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .y_ascii   (y_ascii2),
        .err       (err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack a string, leftmost character as the most significant digit.
    function automatic logic [62:0] ps(input string s);
        logic [62:0] r;
        int          n;
        byte         c;
        r = '0;
        n = s.len();
        for (int i = 0; i < n; i++) begin
            c = s[i];
            r[7*(n-1-i) +: 7] = c[6:0];
        end
        return r;
    endfunction

    // Reference arithmetic on the low nibbles, two-digit operands.
    function automatic logic [20:0] model_y2(input logic [13:0] a, input logic [13:0] b);
        logic [20:0] y;
        logic [4:0]  s;
        logic [4:0]  t;
        logic        c;
        c = 1'b0;
        y = '0;
        for (int i = 0; i < 2; i++) begin
            s = 5'(a[7*i +: 4]) + 5'(b[7*i +: 4]) + 5'(c);
            if (s > 5'd9) begin
                t = s - 5'd10;
                c = 1'b1;
            end else begin
                t = s;
                c = 1'b0;
            end
            y[7*i +: 7] = {3'b011, t[3:0]};
        end
        y[20:14] = {6'b011000, c};
        return y;
    endfunction

    function automatic logic model_err2(input logic [13:0] a, input logic [13:0] b);
        logic e;
        logic [6:0] ca;
        logic [6:0] cb;
        e = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ca = a[7*i +: 7];
            cb = b[7*i +: 7];
            if (ca < 7'h30 || ca > 7'h39 || cb < 7'h30 || cb > 7'h39) e = 1'b1;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [62:0] obs, input logic [62:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full two-digit operation with out_ready high, checking latency.
    task automatic op2(input string tag, input logic [13:0] a, input logic [13:0] b,
                       input logic [20:0] ey, input logic ee);
        a_ascii  = a;
        b_ascii  = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_rdy_T"}, 63'(in_ready), 63'(1'b0));
        chk({tag, "_ov_T"}, 63'(out_valid), 63'(1'b0));
        step();
        chk({tag, "_ov_T1"}, 63'(out_valid), 63'(1'b0));
        step();
        chk({tag, "_ov_T2"}, 63'(out_valid), 63'(1'b1));
        chk({tag, "_y"}, 63'(y_ascii), 63'(ey));
        chk({tag, "_err"}, 63'(err), 63'(ee));
        step();
        chk({tag, "_ov_after"}, 63'(out_valid), 63'(1'b0));
        chk({tag, "_rdy_after"}, 63'(in_ready), 63'(1'b1));
    endtask

    logic [13:0] ta;
    logic [13:0] tb;
    logic [20:0] held_y;

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a_ascii    = '0;
        b_ascii    = '0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        a_ascii2   = '0;
        b_ascii2   = '0;
        out_ready2 = 1'b1;

        step();
        chk("rst_in_ready", 63'(in_ready), 63'(1'b1));
        chk("rst_out_valid", 63'(out_valid), 63'(1'b0));
        chk("rst_y", 63'(y_ascii), ps("000"));
        chk("rst_err", 63'(err), 63'(1'b0));
        chk("rst_y4", 63'(y_ascii2), ps("00000"));
        rst_n = 1'b1;
        step();

        op2("47p85", 14'(ps("47")), 14'(ps("85")), 21'(ps("132")), 1'b0);
        op2("90p09", 14'(ps("90")), 14'(ps("09")), 21'(ps("099")), 1'b0);

        // Back-to-back: second operands held on in_valid during the busy window.
        a_ascii  = 14'(ps("99"));
        b_ascii  = 14'(ps("99"));
        in_valid = 1'b1;
        step();
        a_ascii  = 14'(ps("00"));
        b_ascii  = 14'(ps("00"));
        step();
        chk("b2b_rdy_T1", 63'(in_ready), 63'(1'b0));
        step();
        chk("b2b_ov_T2", 63'(out_valid), 63'(1'b1));
        chk("b2b_y99", 63'(y_ascii), ps("198"));
        step();
        chk("b2b_rdy_T3", 63'(in_ready), 63'(1'b1));
        chk("b2b_ov_T3", 63'(out_valid), 63'(1'b0));
        step();
        in_valid = 1'b0;
        chk("b2b_rdy_T4", 63'(in_ready), 63'(1'b0));
        step();
        chk("b2b_ov_T5", 63'(out_valid), 63'(1'b0));
        step();
        chk("b2b_ov_T6", 63'(out_valid), 63'(1'b1));
        chk("b2b_y00", 63'(y_ascii), ps("000"));
        chk("b2b_err00", 63'(err), 63'(1'b0));
        step();

        // Non-digit characters: 'A' units, then ':' and '/' just outside the range.
        ta = 14'(ps("4A"));
        tb = 14'(ps("12"));
        op2("err_4A", ta, tb, model_y2(ta, tb), model_err2(ta, tb));
        chk("err_4A_hand", 63'(model_y2(ta, tb)), ps("053"));
        ta = 14'(ps("9:"));
        tb = 14'(ps("0/"));
        op2("err_bound", ta, tb, model_y2(ta, tb), 1'b1);
        ta = 14'(ps("O9"));
        tb = 14'(ps("19"));
        op2("err_O9", ta, tb, model_y2(ta, tb), 1'b1);

        // Backpressure in DONE.
        out_ready = 1'b0;
        a_ascii   = 14'(ps("12"));
        b_ascii   = 14'(ps("34"));
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        step();
        step();
        chk("bp_ov", 63'(out_valid), 63'(1'b1));
        chk("bp_y", 63'(y_ascii), ps("046"));
        held_y = y_ascii;
        a_ascii  = 14'(ps("77"));
        b_ascii  = 14'(ps("77"));
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_hold_ov", 63'(out_valid), 63'(1'b1));
            chk("bp_hold_rdy", 63'(in_ready), 63'(1'b0));
            chk("bp_hold_y", 63'(y_ascii), 63'(held_y));
            chk("bp_hold_err", 63'(err), 63'(1'b0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_rel_ov", 63'(out_valid), 63'(1'b0));
        chk("bp_rel_rdy", 63'(in_ready), 63'(1'b1));
        step();
        chk("bp_idle_rdy", 63'(in_ready), 63'(1'b1));

        // Reset during ADD, with an erroneous operand so err is already set.
        a_ascii  = 14'(ps("5A"));
        b_ascii  = 14'(ps("55"));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mrst_rdy", 63'(in_ready), 63'(1'b1));
        chk("mrst_ov", 63'(out_valid), 63'(1'b0));
        chk("mrst_y", 63'(y_ascii), ps("000"));
        chk("mrst_err", 63'(err), 63'(1'b0));
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mrst_no_stale_ov", 63'(out_valid), 63'(1'b0));
            chk("mrst_no_stale_y", 63'(y_ascii), ps("000"));
        end

        op2("post_rst", 14'(ps("38")), 14'(ps("27")), 21'(ps("065")), 1'b0);

        // Four-digit instance: carry ripples through every digit.
        a_ascii2  = 28'(ps("9999"));
        b_ascii2  = 28'(ps("0001"));
        in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        chk("d4_rdy_T", 63'(in_ready2), 63'(1'b0));
        step();
        step();
        step();
        chk("d4_ov_T3", 63'(out_valid2), 63'(1'b0));
        step();
        chk("d4_ov_T4", 63'(out_valid2), 63'(1'b1));
        chk("d4_y", 63'(y_ascii2), ps("10000"));
        chk("d4_err", 63'(err2), 63'(1'b0));
        step();
        chk("d4_ov_after", 63'(out_valid2), 63'(1'b0));
        chk("d4_rdy_after", 63'(in_ready2), 63'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
